ex_stage: RTL and testbench

//  Execute stage of the pipelined MIPS core. Sits directly downstream of ALU control.

---
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ALU, branch resolution, EX/MEM register with valid/ready).
// Define MULT_EN to add a radix-2 shift-add unsigned multiplier on opcode 4'b0110.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [3:0]            alu_ctrl_i,
  input  logic [DATA_W-1:0]     src1_i,
  input  logic [DATA_W-1:0]     src2_i,
  input  logic                  branch_i,
  input  logic                  branch_ne_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_write_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     result_o,
  output logic                  zero_o,
  output logic                  branch_taken_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  illegal_o
);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;

  state_e                  state_q;
  logic                    slotFree, accept, mulOp, legal, aluZero, mulZero, mulLoad;
  logic [DATA_W-1:0]       aluRes, mulRes;
  logic [REG_ADDR_W-1:0]   mulRd;
  logic                    mulRw, mulBeq, mulBne;

  logic                    outValid_q, outValid_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic                    zero_q, zero_d, taken_q, taken_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic                    rw_q, rw_d, illegal_q, illegal_d;

  assign slotFree   = ~outValid_q | out_ready_i;
  assign in_ready_o = (state_q == IDLE) & slotFree & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    aluRes = '0;
    legal  = 1'b1;
    mulOp  = 1'b0;
    case (alu_ctrl_i)
      4'b0000: aluRes = src1_i + src2_i;
      4'b0001: aluRes = src1_i - src2_i;
      4'b0010: aluRes = src1_i & src2_i;
      4'b0011: aluRes = src1_i | src2_i;
      4'b0100: aluRes = ~(src1_i | src2_i);
      4'b0101: aluRes = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
`ifdef MULT_EN
      4'b0110: mulOp = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  assign aluZero = (aluRes == '0);
  assign mulZero = (mulRes == '0);

  // Flush wins; otherwise a load or a drain, else the EX/MEM register holds.
  always_comb begin
    outValid_d = outValid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    taken_d    = taken_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    illegal_d  = illegal_q;
    if (flush_i) begin
      outValid_d = 1'b0;
    end else if (accept && !mulOp) begin
      outValid_d = 1'b1;
      result_d   = aluRes;
      zero_d     = aluZero;
      taken_d    = legal & ((branch_i & aluZero) | (branch_ne_i & ~aluZero));
      rd_d       = rd_addr_i;
      rw_d       = reg_write_i & legal;
      illegal_d  = ~legal;
    end else if (mulLoad) begin
      outValid_d = 1'b1;
      result_d   = mulRes;
      zero_d     = mulZero;
      taken_d    = (mulBeq & mulZero) | (mulBne & ~mulZero);
      rd_d       = mulRd;
      rw_d       = mulRw;
      illegal_d  = 1'b0;
    end else if (out_ready_i) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      taken_q    <= 1'b0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      taken_q    <= taken_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef MULT_EN
  localparam int CNT_W = $clog2(DATA_W);

  state_e                state_d;
  logic [DATA_W-1:0]     mcand_q, mplier_q, acc_q, accNext;
  logic [CNT_W-1:0]      count_q;
  logic [REG_ADDR_W-1:0] mulRd_q;
  logic                  mulRw_q, mulBeq_q, mulBne_q, lastStep;

  assign accNext  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign lastStep = (state_q == MUL) && (count_q == '0);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && mulOp) state_d = MUL;
      MUL:     if (flush_i) state_d = IDLE;
               else if (count_q == '0) state_d = slotFree ? IDLE : HOLD;
      HOLD:    if (flush_i || slotFree) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The final iteration feeds the output register directly when the slot is free.
  always_comb begin
    mulLoad = ~flush_i & slotFree & (lastStep | (state_q == HOLD));
    mulRes  = (state_q == HOLD) ? acc_q : accNext;
    mulRd   = mulRd_q;
    mulRw   = mulRw_q;
    mulBeq  = mulBeq_q;
    mulBne  = mulBne_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      mulRd_q  <= '0;
      mulRw_q  <= 1'b0;
      mulBeq_q <= 1'b0;
      mulBne_q <= 1'b0;
    end else if (accept && mulOp) begin
      mcand_q  <= src1_i;
      mplier_q <= src2_i;
      acc_q    <= '0;
      count_q  <= CNT_W'(DATA_W - 1);
      mulRd_q  <= rd_addr_i;
      mulRw_q  <= reg_write_i;
      mulBeq_q <= branch_i;
      mulBne_q <= branch_ne_i;
    end else if (state_q == MUL) begin
      acc_q    <= accNext;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - 1'b1;
    end
  end
`else
  assign state_q = IDLE;
  assign mulLoad = 1'b0;
  assign mulRes  = '0;
  assign mulRd   = '0;
  assign mulRw   = 1'b0;
  assign mulBeq  = 1'b0;
  assign mulBne  = 1'b0;
`endif

  assign out_valid_o    = outValid_q;
  assign result_o       = result_q;
  assign zero_o         = zero_q;
  assign branch_taken_o = taken_q;
  assign rd_addr_o      = rd_q;
  assign reg_write_o    = rw_q;
  assign illegal_o      = illegal_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; adds multiplier scenarios when MULT_EN is defined.
module tb_ex_stage;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk_i = 1'b0;
  logic                  rst_n;
  logic                  flush_i, in_valid_i, in_ready_o;
  logic [3:0]            alu_ctrl_i;
  logic [DATA_W-1:0]     src1_i, src2_i;
  logic                  branch_i, branch_ne_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  reg_write_i;
  logic                  out_valid_o, out_ready_i;
  logic [DATA_W-1:0]     result_o;
  logic                  zero_o, branch_taken_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic                  reg_write_o, illegal_o;

  // {valid, illegal, reg_write, taken, zero, rd, result}
  logic [41:0] outBus;
  assign outBus = {out_valid_o, illegal_o, reg_write_o, branch_taken_o, zero_o, rd_addr_o, result_o};

  int nCompared   = 0;
  int nMismatched = 0;

  ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .alu_ctrl_i(alu_ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .branch_i(branch_i), .branch_ne_i(branch_ne_i),
    .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .zero_o(zero_o), .branch_taken_o(branch_taken_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [41:0] expOut(input logic v, input logic il, input logic rw,
                                         input logic tk, input logic z,
                                         input logic [4:0] rd, input logic [31:0] r);
    return {v, il, rw, tk, z, rd, r};
  endfunction

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic beq, input logic bne, input logic [4:0] rd, input logic rw);
    in_valid_i  = 1'b1;
    alu_ctrl_i  = op;
    src1_i      = a;
    src2_i      = b;
    branch_i    = beq;
    branch_ne_i = bne;
    rd_addr_i   = rd;
    reg_write_i = rw;
  endtask

  task automatic idleIn;
    in_valid_i  = 1'b0;
    alu_ctrl_i  = 4'b0000;
    src1_i      = '0;
    src2_i      = '0;
    branch_i    = 1'b0;
    branch_ne_i = 1'b0;
    rd_addr_i   = '0;
    reg_write_i = 1'b0;
  endtask

  task automatic test_reset;
    logic [41:0] e;
    rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1; idleIn();
    tick(); tick();
    nCompared++;
    if (outBus !== 42'h0) begin nMismatched++; $display("[TB] FAIL reset_outputs: got %h expected %h", outBus, 42'h0); end
    nCompared++;
    if (in_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_o); end
    rst_n = 1'b1; out_ready_i = 1'b0;
    offer(4'b0000, 32'd1, 32'd2, 1'b0, 1'b0, 5'd3, 1'b1);
    tick();
    offer(4'b0000, 32'd9, 32'd9, 1'b0, 1'b0, 5'd3, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    nCompared++;
    if (outBus !== 42'h0) begin nMismatched++; $display("[TB] FAIL midreset_outputs: got %h expected %h", outBus, 42'h0); end
    tick(); tick();
    nCompared++;
    if (outBus !== 42'h0 || in_ready_o !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL midreset_hold: got %h/%b expected %h/1", outBus, in_ready_o, 42'h0);
    end
    rst_n = 1'b1; out_ready_i = 1'b1;
    offer(4'b0000, 32'd10, 32'd20, 1'b0, 1'b0, 5'd4, 1'b1);
    tick();
    e = expOut(1, 0, 1, 0, 0, 5'd4, 32'd30);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL post_reset_add: got %h expected %h", outBus, e); end
  endtask

  task automatic test_add_sub;
    logic [41:0] e;
    offer(4'b0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 5'd1, 1'b1);
    tick();
    e = expOut(1, 0, 1, 0, 0, 5'd1, 32'h8000_0000);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL add_wrap: got %h expected %h", outBus, e); end
    offer(4'b0001, 32'd5, 32'd5, 1'b1, 1'b0, 5'd2, 1'b1);
    tick();
    e = expOut(1, 0, 1, 1, 1, 5'd2, 32'h0);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL sub_beq: got %h expected %h", outBus, e); end
  endtask

  task automatic test_logic_slt;
    logic [41:0] e;
    offer(4'b0101, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 5'd10, 1'b1);
    tick();
    e = expOut(1, 0, 1, 0, 0, 5'd10, 32'h1);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL slt_neg: got %h expected %h", outBus, e); end
    offer(4'b0101, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd11, 1'b1);
    tick();
    e = expOut(1, 0, 1, 0, 1, 5'd11, 32'h0);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL slt_pos: got %h expected %h", outBus, e); end
    offer(4'b0100, 32'h0, 32'h0, 1'b0, 1'b0, 5'd12, 1'b1);
    tick();
    e = expOut(1, 0, 1, 0, 0, 5'd12, 32'hFFFF_FFFF);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL nor_zero: got %h expected %h", outBus, e); end
    offer(4'b0001, 32'd3, 32'd2, 1'b0, 1'b1, 5'd13, 1'b0);
    tick();
    e = expOut(1, 0, 0, 1, 0, 5'd13, 32'h1);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL bne_taken: got %h expected %h", outBus, e); end
    offer(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 1'b0, 5'd14, 1'b1);
    tick();
    e = expOut(1, 0, 1, 0, 0, 5'd14, 32'h00F0_1200);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL and_beq_not_taken: got %h expected %h", outBus, e); end
  endtask

  task automatic test_back_to_back;
    logic [41:0] e;
    int stableBad;
    offer(4'b0000, 32'd4, 32'd4, 1'b0, 1'b0, 5'd6, 1'b1);
    tick();
    e = expOut(1, 0, 1, 0, 0, 5'd6, 32'd8);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL bp_first: got %h expected %h", outBus, e); end
    out_ready_i = 1'b0;
    offer(4'b0011, 32'hF0, 32'h0F, 1'b0, 1'b0, 5'd7, 1'b1);
    stableBad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (in_ready_o !== 1'b0) stableBad++;
      tick();
      if (outBus !== e) stableBad++;
    end
    nCompared++;
    if (stableBad !== 0) begin nMismatched++; $display("[TB] FAIL bp_hold: got %0d bad samples expected 0", stableBad); end
    out_ready_i = 1'b1;
    #1;
    nCompared++;
    if (in_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready_o); end
    tick();
    e = expOut(1, 0, 1, 0, 0, 5'd7, 32'hFF);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL bp_refill: got %h expected %h", outBus, e); end
    idleIn();
    tick();
    nCompared++;
    if (out_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_drain: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_illegal;
    logic [41:0] e;
    offer(4'b1111, 32'd5, 32'd6, 1'b1, 1'b0, 5'd9, 1'b1);
    tick();
    e = expOut(1, 1, 0, 0, 1, 5'd9, 32'h0);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL illegal_1111: got %h expected %h", outBus, e); end
`ifndef MULT_EN
    offer(4'b0110, 32'd7, 32'd6, 1'b0, 1'b1, 5'd8, 1'b1);
    tick();
    e = expOut(1, 1, 0, 0, 1, 5'd8, 32'h0);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL illegal_0110: got %h expected %h", outBus, e); end
`endif
  endtask

  task automatic test_flush;
    flush_i = 1'b1;
    offer(4'b0000, 32'd1, 32'd1, 1'b0, 1'b0, 5'd1, 1'b1);
    #1;
    nCompared++;
    if (in_ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready_o); end
    tick();
    flush_i = 1'b0;
    idleIn();
    nCompared++;
    if (out_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_clears_valid: got %b expected 0", out_valid_o); end
  endtask

`ifdef MULT_EN
  task automatic test_mult;
    logic [41:0] e;
    int lowCycles, highCycles;
    out_ready_i = 1'b1;
    offer(4'b0110, 32'd7, 32'd6, 1'b0, 1'b0, 5'd8, 1'b1);
    tick();
    idleIn();
    lowCycles = 0;
    for (int c = 1; c <= DATA_W; c++) begin
      if (out_valid_o === 1'b0 && in_ready_o === 1'b0) lowCycles++;
      tick();
    end
    nCompared++;
    if (lowCycles !== DATA_W) begin nMismatched++; $display("[TB] FAIL mul_busy_cycles: got %0d expected %0d", lowCycles, DATA_W); end
    e = expOut(1, 0, 1, 0, 0, 5'd8, 32'd42);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL mul_result: got %h expected %h", outBus, e); end
    tick();
    nCompared++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL mul_back_idle: got ready %b valid %b expected 1/0", in_ready_o, out_valid_o);
    end
    offer(4'b0110, 32'd7, 32'd6, 1'b0, 1'b0, 5'd8, 1'b1);
    tick();
    idleIn();
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    nCompared++;
    if (in_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL mul_flush_idle: got %b expected 1", in_ready_o); end
    highCycles = 0;
    for (int c = 0; c < DATA_W; c++) begin
      if (out_valid_o !== 1'b0) highCycles++;
      tick();
    end
    nCompared++;
    if (highCycles !== 0) begin nMismatched++; $display("[TB] FAIL mul_flush_no_valid: got %0d expected 0", highCycles); end
    offer(4'b0000, 32'd2, 32'd3, 1'b0, 1'b0, 5'd5, 1'b1);
    tick();
    idleIn();
    e = expOut(1, 0, 1, 0, 0, 5'd5, 32'd5);
    nCompared++;
    if (outBus !== e) begin nMismatched++; $display("[TB] FAIL mul_flush_then_add: got %h expected %h", outBus, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_logic_slt();
    test_back_to_back();
    test_illegal();
    test_flush();
`ifdef MULT_EN
    test_mult();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
